// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - PS/2 line, enable and received-byte signal bundle
// The master side drives the PS/2 lines and rx_en; the slave is the receiver.
interface ps2_rx_if;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       err_tick;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output ps2c, ps2d, rx_en,
    input  dout, rx_done_tick, err_tick, parity_err, frame_err
  );

  modport slave (
    input  ps2c, ps2d, rx_en,
    output dout, rx_done_tick, err_tick, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver
// Synchronizes and filters ps2c, shifts in 11-bit frames, checks parity/stop and times out stalls.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  ps2_rx_if.slave    bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, DATA} state_t;

  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fc_q, fc_d;
  logic                  fall;
  logic                  bit_in;

  state_t                state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  // b[0] would only ever be shifted out unread, so just b[10:1] is stored.
  logic [10:1]           b_q, b_d;
  logic [10:0]           b_shift;
  logic [7:0]            dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_c, ferr_c;

  assign filt_d = {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
  assign fc_d   = (&filt_d) ? 1'b1 : ((~|filt_d) ? 1'b0 : fc_q);
  assign fall   = fc_q & ~fc_d;
  assign bit_in = d_sync_q[1];

  assign b_shift = {bit_in, b_q[10:1]};
  assign perr_c  = ~(^{b_shift[8:1], b_shift[9]});
  assign ferr_c  = ~b_shift[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      filt_q   <= '1;
      fc_q     <= 1'b1;
      state_q  <= IDLE;
      n_q      <= 4'd0;
      tmo_q    <= '0;
      b_q      <= '0;
      dout_q   <= 8'h00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      c_sync_q <= {c_sync_q[0], bus.ps2c};
      d_sync_q <= {d_sync_q[0], bus.ps2d};
      filt_q   <= filt_d;
      fc_q     <= fc_d;
      state_q  <= state_d;
      n_q      <= n_d;
      tmo_q    <= tmo_d;
      b_q      <= b_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      err_q    <= err_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    tmo_d   = tmo_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    case (state_q)
      IDLE: begin
        if (fall && bus.rx_en && !bit_in) begin
          b_d     = b_shift[10:1];
          n_d     = 4'd9;
          tmo_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          b_d   = b_shift[10:1];
          tmo_d = '0;
          if (n_q == 4'd0) begin
            state_d = IDLE;
            if (!perr_c && !ferr_c) begin
              dout_d = b_shift[8:1];
              done_d = 1'b1;
              perr_d = 1'b0;
              ferr_d = 1'b0;
            end else begin
              perr_d = perr_c;
              ferr_d = ferr_c;
              err_d  = 1'b1;
            end
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Counter reaches TIMEOUT_CYCLES on this edge: abort the stalled frame.
          state_d = IDLE;
          tmo_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.err_tick     = err_q;
  assign bus.parity_err   = perr_q;
  assign bus.frame_err    = ferr_q;
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receives PS/2 device-to-host frames (start, 8 data bits LSB first, odd parity, stop) on the raw `ps2c`/`ps2d` lines and emits one byte per valid frame. It sits directly upstream of the hex-display byte buffer. `dout`/`rx_done_tick` drive that buffer's `data`/`data_ready` inputs. Malformed frames are reported on separate error outputs and never produce `rx_done_tick`.

## Interface
Parameters:
- `FILTER_LEN`, 8: number of consecutive equal synchronized `ps2c` samples required to change the filtered clock level; must be ≥ 2.
- `TIMEOUT_CYCLES`, 50000: maximum `clk` cycles allowed between consecutive filtered falling edges inside a frame (1 ms at 50 MHz).

Ports:
- `clk`  in  1: system clock. One clock domain; the reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high reset.
- `ps2c`  in  1: raw PS/2 clock, asynchronous.
- `ps2d`  in  1: raw PS/2 data, asynchronous.
- `rx_en`  in  1: when 1, a new frame may start in IDLE.
- `dout`  out  8: last valid received byte; holds until the next valid frame.
- `rx_done_tick`  out  1: one-cycle pulse; a valid byte has just been loaded into `dout`.
- `err_tick`  out  1: one-cycle pulse; a frame was rejected.
- `parity_err`  out  1: registered; result of the last completed or aborted frame.
- `frame_err`  out  1: registered; bad stop bit or timeout on the last frame.

## Operation
- **Input synchronizers:** `ps2c` and `ps2d` each pass through a 2-flop synchronizer. Both synchronizers reset to 1.
- **Clock filter:** `FILTER_LEN`-bit shift register, reset to all 1s. It shifts in the synchronized `ps2c` every cycle.
  - Filtered level `fc` (reset 1) becomes 1 when the next register value is all 1s.
  - `fc` becomes 0 when the next register value is all 0s.
  - Otherwise `fc` holds.
  - `fall` is asserted when `fc` = 1 and the next value of `fc` = 0.
- **Bit sampling:** on a `fall` cycle, the bit taken is the synchronized `ps2d` value.
- **Frame register:** 11-bit shift register `b`; each accepted bit is shifted in as `b <= {bit, b[10:1]}`. 4-bit down-counter `n`.
- **FSM: IDLE.**
  - On `fall` with `rx_en`=1 and bit=0 (start bit): shift in the bit, set `n` = 9, clear the timeout counter, go to DATA.
  - On `fall` with bit=1, or with `rx_en`=0: ignore and stay in IDLE.
- **FSM: DATA.**
  - On `fall`: shift in the bit and clear the timeout counter.
  - If `n` = 0, this bit is the stop bit: evaluate the frame, go to IDLE.
  - Otherwise decrement `n`.
  - With no `fall`: increment the timeout counter (width `$clog2(TIMEOUT_CYCLES+1)`).
  - When the timeout counter reaches `TIMEOUT_CYCLES`: abort to IDLE, set `frame_err`=1 and `parity_err`=0, pulse `err_tick`. `dout` is unchanged.
- **Frame evaluation** on the next value of `b`: data = `b[8:1]`, parity = `b[9]`, stop = `b[10]`.
  - `perr` = ~(^{data, parity}).
  - `ferr` = ~stop.
  - If both are 0: `dout` <= data, pulse `rx_done_tick`, clear both error flags.
  - Otherwise: `parity_err` <= `perr`, `frame_err` <= `ferr`, pulse `err_tick`; `dout` is unchanged.
- **`rx_en` deasserted mid-frame:** the frame still completes normally.
- **Reset** (any state, including mid-frame):
  - State IDLE, `n`=0, timeout counter 0, `b`=0.
  - `dout`=8'h00; `rx_done_tick`, `err_tick`, `parity_err`, `frame_err` all 0.
  - Filter and synchronizers all 1s, `fc`=1.
  - Any edges left over from an interrupted frame are handled by the normal start, parity and stop checks and the timeout. None of them may produce `rx_done_tick` unless they happen to form a valid frame.

## Timing
- Let edge k be the first rising edge of `clk` that captures `ps2c`=0 into synchronizer stage 1, with `ps2c` held low afterwards. The bit is consumed at edge k+`FILTER_LEN`+1.
- A low or high glitch of fewer than `FILTER_LEN` synchronized samples never changes `fc`.
- `rx_done_tick` / `err_tick` are high for exactly the one cycle following the stop-bit edge. `dout` and the error flags change at that same edge.
- The timeout abort occurs `TIMEOUT_CYCLES` cycles after the last accepted `fall`. `err_tick` is high in the cycle after the abort edge.
- `rx_done_tick` and `err_tick` are never high together.
- A new start bit is accepted on the first `fall` after returning to IDLE, so back-to-back frames are supported.

## Test plan
Bench settings: `FILTER_LEN`=8, `TIMEOUT_CYCLES`=200, PS/2 half-period = 40 clk.
- Send 8'h1C with parity 0, stop 1 -> exactly one `rx_done_tick`, `dout`=8'h1C, both error flags 0. Edge-to-tick latency matches the Timing section exactly.
- Send 8'hF0 (parity 1) then immediately 8'h1C -> two `rx_done_tick` pulses; `dout` holds F0 between them, then becomes 1C.
- Send 8'h1C with parity 1 -> `err_tick` one cycle, `parity_err`=1, `frame_err`=0, `dout` unchanged. Send 8'h1C with stop 0 -> `frame_err`=1.
- Send start plus 4 bits, then hold `ps2c` high -> `err_tick` 200 cycles after the last fall, `frame_err`=1, no `rx_done_tick`. A following valid 8'hF0 frame gives `dout`=F0 with the error flags cleared.
- Apply 7-cycle low pulses on `ps2c` -> no bit is accepted. Send a full frame with `rx_en`=0 -> no ticks, state remains IDLE.
- Assert `reset` for one cycle after the 5th bit of a frame -> all outputs 0 from the next cycle. After idling more than 200 cycles, a valid 8'h1C frame is received correctly.
